simon_key_sched: RTL

- Parametrised Simon key-expansion engine, successor to the fixed 128/256 schedule.
- Supports word width 32 or 64 and 2, 3 or 4 key words.
- Expands the master key into T round keys held in an internal array, then serves them through a registered random-access read port.
- Sits between the key input and the encrypt/decrypt datapaths. Round keys are read by index, so decrypt can walk them downward.

---
 rtl/simon_pkg.sv | 45 ++++
 rtl/simon_ks_round.sv | 37 +++
 rtl/simon_key_sched.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared Simon key-schedule definitions: z-sequence constants, the
// round-count / z-sequence selection functions and the controller states.
package simon_pkg;

  // z sequences, LSB-first: bit j is z[j]. Only 62 bits are significant.
  localparam logic [61:0] Z2     = 62'h3369F885192C0EF5;
  localparam logic [61:0] Z3     = 62'h3C2CE51207A635DB;
  localparam logic [63:0] Z4_RAW = 64'h3DC94C3A046D678B;
  localparam logic [61:0] Z4     = Z4_RAW[61:0];

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    GEN  = 3'd2,
    DONE = 3'd3,
    WIPE = 3'd4
  } state_t;

  // Number of round keys T for a (word width, key words) pair; 0 = illegal.
  function automatic int rounds_f(input int word_w, input int key_words);
    int t;
    t = 32'sd0;
    if (word_w == 32'sd32 && key_words == 32'sd3)      t = 32'sd42;
    else if (word_w == 32'sd32 && key_words == 32'sd4) t = 32'sd44;
    else if (word_w == 32'sd64 && key_words == 32'sd2) t = 32'sd68;
    else if (word_w == 32'sd64 && key_words == 32'sd3) t = 32'sd69;
    else if (word_w == 32'sd64 && key_words == 32'sd4) t = 32'sd72;
    else t = 32'sd0;
    return t;
  endfunction

  // z sequence used by a (word width, key words) pair.
  function automatic logic [61:0] zsel_f(input int word_w, input int key_words);
    logic [61:0] z;
    z = 62'd0;
    if (word_w == 32'sd32 && key_words == 32'sd3)      z = Z2;
    else if (word_w == 32'sd32 && key_words == 32'sd4) z = Z3;
    else if (word_w == 32'sd64 && key_words == 32'sd2) z = Z2;
    else if (word_w == 32'sd64 && key_words == 32'sd3) z = Z3;
    else if (word_w == 32'sd64 && key_words == 32'sd4) z = Z4;
    else z = 62'd0;
    return z;
  endfunction

endpackage

// File: rtl/simon_ks_round.sv
// Combinational Simon next-round-key function over an M-word window.
// Window word 0 is k[i-M] (oldest), word M-1 is k[i-1] (newest).
module simon_ks_round
  import simon_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int KEY_WORDS = 4
) (
  input  logic [KEY_WORDS*WORD_W-1:0] window,
  input  logic                        zbit,
  output logic [WORD_W-1:0]           next_key
);

  logic [WORD_W-1:0] k_old_s;
  logic [WORD_W-1:0] k_new_s;
  logic [WORD_W-1:0] tmp_a_s;
  logic [WORD_W-1:0] tmp_b_s;
  logic [WORD_W-1:0] const_s;

  assign k_old_s = window[0 +: WORD_W];
  assign k_new_s = window[(KEY_WORDS-1)*WORD_W +: WORD_W];
  // The constant c = 2^n - 4 folds into "~k ^ 3"; z enters at bit 0 only.
  assign const_s = {{(WORD_W-2){1'b0}}, 2'b11} ^ {{(WORD_W-1){1'b0}}, zbit};

  // Next key: ror3 of newest word, optional k[i-3] mix, ror1 fold, constants
  always_comb begin
    tmp_a_s = {k_new_s[2:0], k_new_s[WORD_W-1:3]};
    if (KEY_WORDS == 4) begin
      tmp_a_s = tmp_a_s ^ window[WORD_W +: WORD_W];
    end else begin
      tmp_a_s = tmp_a_s;
    end
    tmp_b_s  = tmp_a_s ^ {tmp_a_s[0], tmp_a_s[WORD_W-1:1]};
    next_key = ~k_old_s ^ tmp_b_s ^ const_s;
  end

endmodule

// File: rtl/simon_key_sched.sv
// Parametrised Simon key-expansion engine with a registered random-access
// round-key read port. Optional macro SIMON_KS_ZEROIZE_EN adds a zeroize
// input and a WIPE state that clears the round-key array.
module simon_key_sched
  import simon_pkg::*;
#(
  parameter int WORD_W    = 64,
  parameter int KEY_WORDS = 4,
  parameter int ADDR_W    = 7
) (
  input  logic                        clk,
  input  logic                        res_n,
  input  logic                        start,
`ifdef SIMON_KS_ZEROIZE_EN
  input  logic                        zeroize,
`endif
  input  logic [KEY_WORDS*WORD_W-1:0] keys,
  output logic                        busy,
  output logic                        done,
  input  logic                        rk_rd,
  input  logic [ADDR_W-1:0]           rk_addr,
  output logic [WORD_W-1:0]           rk_data,
  output logic                        rk_err
);

  localparam int               T         = rounds_f(WORD_W, KEY_WORDS);
  localparam logic [61:0]      ZSEQ      = zsel_f(WORD_W, KEY_WORDS);
  localparam int               DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] RND_FIRST = ADDR_W'(KEY_WORDS);
  localparam logic [ADDR_W-1:0] RND_LAST  = ADDR_W'(T - 1);
  localparam logic [ADDR_W-1:0] RND_END   = ADDR_W'(T);
  localparam logic [ADDR_W:0]   T_LIM     = (ADDR_W+1)'(T);

  generate
    if (T == 0) begin : g_bad_cfg
      $fatal(1, "simon_key_sched: unsupported WORD_W/KEY_WORDS combination");
    end
    if (DEPTH <= T) begin : g_bad_addr
      $fatal(1, "simon_key_sched: ADDR_W too small for the round count");
    end
  endgenerate

  state_t                      state_r;
  logic                        busy_r;
  logic                        done_r;
  logic [ADDR_W-1:0]           rnd_r;
  logic [5:0]                  zidx_r;
  logic [KEY_WORDS*WORD_W-1:0] window_r;
  logic [WORD_W-1:0]           next_key_s;
  logic                        zero_req_s;
  logic                        load_en_s;
  logic                        wr_en_s;
  logic [ADDR_W-1:0]           wr_addr_s;
  logic [WORD_W-1:0]           wr_data_s;
  logic [WORD_W-1:0]           rk_mem_r [0:DEPTH-1];
  logic [WORD_W-1:0]           rk_data_r;
  logic                        rk_err_r;

`ifdef SIMON_KS_ZEROIZE_EN
  assign zero_req_s = zeroize;
`else
  assign zero_req_s = 1'b0;
`endif

  simon_ks_round #(
    .WORD_W    (WORD_W),
    .KEY_WORDS (KEY_WORDS)
  ) u_round (
    .window   (window_r),
    .zbit     (ZSEQ[zidx_r]),
    .next_key (next_key_s)
  );

  // Expansion controller: state, key window, round/z counters, busy/done
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rnd_r    <= {ADDR_W{1'b0}};
      zidx_r   <= 6'd0;
      window_r <= {(KEY_WORDS*WORD_W){1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (zero_req_s) begin
            state_r <= WIPE;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            rnd_r   <= {ADDR_W{1'b0}};
          end else if (start) begin
            state_r  <= LOAD;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            window_r <= keys;
          end
        end
        LOAD: begin
          if (zero_req_s) begin
            state_r <= WIPE;
            rnd_r   <= {ADDR_W{1'b0}};
          end else begin
            state_r <= GEN;
            rnd_r   <= RND_FIRST;
            zidx_r  <= 6'd0;
          end
        end
        GEN: begin
          if (zero_req_s) begin
            state_r <= WIPE;
            rnd_r   <= {ADDR_W{1'b0}};
          end else if (rnd_r == RND_END) begin
            // Last key k[T-1] was written on the previous edge.
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            window_r <= {next_key_s, window_r[KEY_WORDS*WORD_W-1:WORD_W]};
            rnd_r    <= rnd_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            zidx_r   <= (zidx_r == 6'd61) ? 6'd0 : zidx_r + 6'd1;
          end
        end
`ifdef SIMON_KS_ZEROIZE_EN
        WIPE: begin
          if (rnd_r == RND_LAST) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            rnd_r   <= {ADDR_W{1'b0}};
          end else begin
            rnd_r <= rnd_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          rnd_r   <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // Array write port select: master-key load, generated key, or wipe zero
  always_comb begin
    load_en_s = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = rnd_r;
    wr_data_s = next_key_s;
    case (state_r)
      IDLE, DONE: begin
        if (start && !zero_req_s) load_en_s = 1'b1;
        else                      load_en_s = 1'b0;
      end
      GEN: begin
        if (!zero_req_s && (rnd_r != RND_END)) wr_en_s = 1'b1;
        else                                   wr_en_s = 1'b0;
      end
`ifdef SIMON_KS_ZEROIZE_EN
      WIPE: begin
        wr_en_s   = 1'b1;
        wr_data_s = {WORD_W{1'b0}};
      end
`endif
      default: begin
        load_en_s = 1'b0;
        wr_en_s   = 1'b0;
      end
    endcase
  end

  // Round-key array; unreset storage, only readable once done is set
  always_ff @(posedge clk) begin
    if (load_en_s) begin
      for (int j = 0; j < KEY_WORDS; j++) begin
        rk_mem_r[j] <= keys[j*WORD_W +: WORD_W];
      end
    end else if (wr_en_s) begin
      rk_mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Registered read port, gated on done and index range
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rk_data_r <= {WORD_W{1'b0}};
      rk_err_r  <= 1'b0;
    end else if (rk_rd) begin
      if (done_r && ({1'b0, rk_addr} < T_LIM)) begin
        rk_data_r <= rk_mem_r[rk_addr];
        rk_err_r  <= 1'b0;
      end else begin
        rk_data_r <= {WORD_W{1'b0}};
        rk_err_r  <= 1'b1;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign rk_data = rk_data_r;
  assign rk_err  = rk_err_r;

endmodule
